// File: rtl/byte_op_ctrl_pkg.sv
// Shared definitions for the byte-op sequencer: byte_manip op encodings,
// the highest legal op code, the controller state set and a legality helper.
package byte_op_ctrl_pkg;

  typedef enum logic [2:0] {
    BM_MOVL  = 3'd0,
    BM_MOVLZ = 3'd1,
    BM_MOVLS = 3'd2,
    BM_MOVH  = 3'd3,
    BM_SWPB  = 3'd4
  } bm_op_e;

  localparam logic [2:0] BM_OP_MAX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EXEC,
    ST_WB
  } ctrl_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= BM_OP_MAX;
  endfunction

endpackage

// File: rtl/byte_manip.sv
// Combinational 16-bit byte-manipulation unit.
// Ports:
//   i_e   enable; when low the destination value passes through unchanged
//   i_op  operation (MOVL/MOVLZ/MOVLS/MOVH/SWPB); other codes pass through
//   i_d   current destination register value
//   i_b   immediate byte (unused by SWPB)
//   o_y   result
module byte_manip
  import byte_op_ctrl_pkg::*;
(
  input  logic        i_e,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_d,
  input  logic [7:0]  i_b,
  output logic [15:0] o_y
);

  always_comb begin
    o_y = i_d;
    if (i_e) begin
      case (i_op)
        BM_MOVL:  o_y = {i_d[15:8], i_b};
        BM_MOVLZ: o_y = {8'h00, i_b};
        BM_MOVLS: o_y = {8'hFF, i_b};
        BM_MOVH:  o_y = {i_b, i_d[7:0]};
        BM_SWPB:  o_y = {i_d[7:0], i_d[15:8]};
        default:  o_y = i_d;
      endcase
    end
  end

endmodule

// File: rtl/byte_op_ctrl.sv
// Byte-op sequencer: accepts a decoded byte-op request, reads the destination
// register, runs byte_manip on it and writes the result back.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_op/req_dst/req_byte   op code, destination index, immediate byte
//   rf_rd_en/rf_rd_addr       register-file read strobe and index
//   rf_rd_data                read data, RF_RD_LAT cycles after rf_rd_en
//   rf_wr_en/addr/data        register-file write port (addr/data hold outside WB)
//   busy                      request in flight
//   done                      one-cycle pulse on write-back
//   err                       one-cycle pulse after an illegal op is rejected
module byte_op_ctrl
  import byte_op_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 3,
  parameter int RF_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [REG_AW-1:0] req_dst,
  input  logic [7:0]        req_byte,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (RF_RD_LAT > 1) ? $clog2(RF_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RF_RD_LAT - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_next;
  logic [2:0]        r_op;
  logic [REG_AW-1:0] r_dst;
  logic [7:0]        r_byte;
  logic [DATA_W-1:0] r_dst_data;
  logic [DATA_W-1:0] r_result;
  logic [REG_AW-1:0] r_wr_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              w_xfer;
  logic              w_accept;
  logic              w_illegal;
  logic              w_rd_last;
  logic [DATA_W-1:0] w_manip;

  assign w_xfer    = req_valid && (r_state == ST_IDLE);
  assign w_accept  = w_xfer && op_legal(req_op);
  assign w_illegal = w_xfer && !op_legal(req_op);
  assign w_rd_last = (r_state == ST_WAIT) && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rf_rd_en  = 1'b0;
    rf_wr_en  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) w_next = ST_READ;
      end
      ST_READ: begin
        rf_rd_en = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_WAIT: if (r_cnt == '0) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_WB;
      ST_WB: begin
        rf_wr_en = 1'b1;
        done     = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Write address is snapshotted with the result so both hold their
  // last written values while idle, independent of later requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_dst      <= '0;
      r_byte     <= '0;
      r_dst_data <= '0;
      r_result   <= '0;
      r_wr_addr  <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_accept) begin
        r_op   <= req_op;
        r_dst  <= req_dst;
        r_byte <= req_byte;
      end
      if (r_state == ST_READ)
        r_cnt <= CNT_LOAD;
      else if ((r_state == ST_WAIT) && (r_cnt != '0))
        r_cnt <= r_cnt - CNT_W'(1);
      if (w_rd_last)
        r_dst_data <= rf_rd_data;
      if (r_state == ST_EXEC) begin
        r_result  <= w_manip;
        r_wr_addr <= r_dst;
      end
    end
  end

  byte_manip u_byte_manip (
    .i_e  (1'b1),
    .i_op (r_op),
    .i_d  (r_dst_data),
    .i_b  (r_byte),
    .o_y  (w_manip)
  );

  assign rf_rd_addr = r_dst;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_result;
  assign err        = r_err;

endmodule
